uart_tx_arb: RTL and testbench

Two-requester arbiter that shares the single UART transmit path (`uart_top` `i_tx_data`/`i_tx_stb`/`o_tx_busy`) between the command sequencer's result stream and a second byte source, such as a status/debug message emitter. Each requester has a small FIFO. A round-robin scheduler pops one byte at a time and drives a one-cycle transmit strobe. It then tracks the UART busy handshake, with a timeout guard, before granting the next byte. The block sits between `seq` / the second source and `uart_top` in the board top level.

---
 rtl/uart_tx_arb.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one UART transmit path between two byte FIFOs

module uart_tx_arb_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          not_empty
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;

    // A full FIFO refuses a push even when it pops in the same cycle.
    assign in_ready  = (count != CNT_FULL);
    assign push      = in_valid & in_ready;
    assign not_empty = (count != '0);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_tx_arb #(
    parameter int DW      = 8,
    parameter int FIFO_AW = 2,
    parameter int BUSY_TO = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_req0_data,
    input  logic          i_req0_valid,
    output logic          o_req0_ready,
    input  logic [DW-1:0] i_req1_data,
    input  logic          i_req1_valid,
    output logic          o_req1_ready,
    output logic [DW-1:0] o_tx_data,
    output logic          o_tx_stb,
    input  logic          i_tx_busy,
    output logic [1:0]    o_grant,
    output logic [7:0]    o_sent0,
    output logic [7:0]    o_sent1,
    output logic          o_to_err
);
    localparam int TW = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] timer;
    logic [DW-1:0] head0;
    logic [DW-1:0] head1;
    logic          ne0;
    logic          ne1;
    logic          take;
    logic          sel1;
    logic          pop0;
    logic          pop1;
    logic          stb_d;

    uart_tx_arb_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (i_req0_data),
        .in_valid  (i_req0_valid),
        .in_ready  (o_req0_ready),
        .pop       (pop0),
        .head      (head0),
        .not_empty (ne0)
    );

    uart_tx_arb_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (i_req1_data),
        .in_valid  (i_req1_valid),
        .in_ready  (o_req1_ready),
        .pop       (pop1),
        .head      (head1),
        .not_empty (ne1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!i_tx_busy && (ne0 || ne1)) next_state = ISSUE;
            ISSUE:   next_state = WAIT_HI;
            WAIT_HI: begin
                if (i_tx_busy) begin
                    next_state = WAIT_LO;
                end else if (timer == '0) begin
                    next_state = IDLE;
                end
            end
            WAIT_LO: if (!i_tx_busy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // On a tie, the requester that did not get the previous byte wins.
    always_comb begin
        take  = (state == IDLE) && !i_tx_busy && (ne0 || ne1);
        sel1  = ne1 && (!ne0 || o_grant[0]);
        pop0  = take && !sel1;
        pop1  = take && sel1;
        stb_d = (next_state == ISSUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_tx_stb  <= 1'b0;
            o_tx_data <= '0;
            o_grant   <= 2'b10;
            o_sent0   <= 8'd0;
            o_sent1   <= 8'd0;
            o_to_err  <= 1'b0;
            timer     <= '0;
        end else begin
            o_tx_stb <= stb_d;
            if (take) begin
                o_tx_data <= sel1 ? head1 : head0;
                o_grant   <= sel1 ? 2'b10 : 2'b01;
            end
            if (state == ISSUE) begin
                timer <= TW'(BUSY_TO);
                if (o_grant[0]) begin
                    o_sent0 <= o_sent0 + 8'd1;
                end else begin
                    o_sent1 <= o_sent1 + 8'd1;
                end
            end
            // The byte was already counted at issue; a timeout only raises the flag.
            if (state == WAIT_HI && !i_tx_busy) begin
                if (timer == '0) begin
                    o_to_err <= 1'b1;
                end else begin
                    timer <= timer - TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - scoreboard bench for uart_tx_arb with a simple UART busy model

module tb_uart_tx_arb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req0_data = 8'd0;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req1_data = 8'd0;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [7:0] tx_data;
    logic       tx_stb;
    logic       tx_busy;
    logic [1:0] grant;
    logic [7:0] sent0;
    logic [7:0] sent1;
    logic       to_err;

    int         checks = 0;
    int         failures = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_e;
    int         busy_cnt = 0;
    int         busy_len = 20;
    bit         model_on = 1'b1;
    logic       hold_busy = 1'b0;
    bit         ok;

    assign tx_busy = hold_busy | (busy_cnt != 0);

    always #5 clk = ~clk;

    uart_tx_arb #(.DW(8), .FIFO_AW(2), .BUSY_TO(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req0_data  (req0_data),
        .i_req0_valid (req0_valid),
        .o_req0_ready (req0_ready),
        .i_req1_data  (req1_data),
        .i_req1_valid (req1_valid),
        .o_req1_ready (req1_ready),
        .o_tx_data    (tx_data),
        .o_tx_stb     (tx_stb),
        .i_tx_busy    (tx_busy),
        .o_grant      (grant),
        .o_sent0      (sent0),
        .o_sent1      (sent1),
        .o_to_err     (to_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // UART model and scoreboard consumer
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            exp_q.delete();
        end else begin
            if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
            if (tx_stb) begin
                if (model_on) busy_cnt = busy_len;
                if (exp_q.size() == 0) begin
                    chk("unexpected_stb", 32'(tx_data), 32'hffff_ffff);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(exp_e[7:0]));
                    chk("tx_grant", 32'(grant), 32'(exp_e[9:8]));
                end
            end
        end
    end

    task automatic push(input int r, input logic [7:0] d, output bit accepted);
        @(negedge clk);
        if (r == 0) begin
            req0_data  = d;
            req0_valid = 1'b1;
            accepted   = req0_ready;
        end else begin
            req1_data  = d;
            req1_valid = 1'b1;
            accepted   = req1_ready;
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic send(input int r, input logic [7:0] d);
        bit acc;
        exp_q.push_back({(r == 0) ? 2'b01 : 2'b10, d});
        push(r, d, acc);
        chk("push_accept", 32'(acc), 1);
    endtask

    task automatic wait_stb(input int max);
        int n = 0;
        while (!tx_stb && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_stb", 32'(tx_stb), 1);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain", 32'(n < max), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        hold_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_stb", 32'(tx_stb), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_grant", 32'(grant), 2);
        chk("rst_sent0", 32'(sent0), 0);
        chk("rst_sent1", 32'(sent1), 0);
        chk("rst_to_err", 32'(to_err), 0);
        chk("rst_ready0", 32'(req0_ready), 1);
        chk("rst_ready1", 32'(req1_ready), 1);
        rst = 1'b0;

        // single byte with latency and a 20-cycle busy
        busy_len = 20;
        send(0, 8'h41);
        chk("lat_pre", 32'(tx_stb), 0);
        @(negedge clk);
        chk("lat_stb", 32'(tx_stb), 1);
        @(negedge clk);
        chk("single_stb_width", 32'(tx_stb), 0);
        chk("single_sent0", 32'(sent0), 1);
        chk("single_grant", 32'(grant), 1);
        drain(100);
        chk("single_sent0_end", 32'(sent0), 1);

        // round robin after preload under busy
        do_reset();
        hold_busy = 1'b1;
        busy_len = 2;
        exp_q.push_back({2'b01, 8'h10});
        exp_q.push_back({2'b10, 8'h20});
        exp_q.push_back({2'b01, 8'h11});
        exp_q.push_back({2'b10, 8'h21});
        exp_q.push_back({2'b01, 8'h12});
        push(0, 8'h10, ok); chk("rr_acc", 32'(ok), 1);
        push(0, 8'h11, ok); chk("rr_acc", 32'(ok), 1);
        push(0, 8'h12, ok); chk("rr_acc", 32'(ok), 1);
        push(1, 8'h20, ok); chk("rr_acc", 32'(ok), 1);
        push(1, 8'h21, ok); chk("rr_acc", 32'(ok), 1);
        repeat (3) @(negedge clk);
        chk("rr_held", 32'(exp_q.size()), 5);
        hold_busy = 1'b0;
        drain(300);
        chk("rr_sent0", 32'(sent0), 3);
        chk("rr_sent1", 32'(sent1), 2);

        // full FIFO refuses the fifth push
        do_reset();
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(1, 8'(8'h60 + i));
        end
        chk("full_ready1", 32'(req1_ready), 0);
        push(1, 8'h64, ok);
        chk("full_refuse", 32'(ok), 0);
        hold_busy = 1'b0;
        drain(300);
        chk("full_sent1", 32'(sent1), 4);

        // busy never rises: timeout flag after BUSY_TO+1 wait cycles
        do_reset();
        model_on = 1'b0;
        send(0, 8'h55);
        wait_stb(10);
        repeat (16) @(negedge clk);
        chk("to_err_early", 32'(to_err), 0);
        @(negedge clk);
        chk("to_err_set", 32'(to_err), 1);
        send(0, 8'h56);
        @(negedge clk);
        chk("to_next_stb", 32'(tx_stb), 1);
        drain(100);
        chk("to_sent0", 32'(sent0), 2);
        chk("to_err_sticky", 32'(to_err), 1);
        model_on = 1'b1;

        // asynchronous reset while waiting for busy to fall
        do_reset();
        busy_len = 20;
        send(0, 8'h30);
        wait_stb(10);
        push(0, 8'h31, ok); chk("mid_acc", 32'(ok), 1);
        push(0, 8'h32, ok); chk("mid_acc", 32'(ok), 1);
        chk("mid_sent0_pre", 32'(sent0), 1);
        rst = 1'b1;
        #1;
        chk("mid_stb", 32'(tx_stb), 0);
        chk("mid_sent0", 32'(sent0), 0);
        chk("mid_ready0", 32'(req0_ready), 1);
        chk("mid_ready1", 32'(req1_ready), 1);
        chk("mid_data", 32'(tx_data), 0);
        chk("mid_grant", 32'(grant), 2);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_quiet_sent0", 32'(sent0), 0);

        // counter wrap after 256 bytes on req0
        do_reset();
        busy_len = 1;
        for (int i = 0; i < 256; i++) begin
            send(0, 8'(i));
            drain(60);
            if (i == 254) chk("wrap_sent0_255", 32'(sent0), 255);
        end
        chk("wrap_sent0", 32'(sent0), 0);
        chk("wrap_sent1", 32'(sent1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
